// File: rtl/elstc_buff_if.sv
// Status and control bundle between the RX elastic buffer and its sequencing controller.
// The master modport is the controller; the slave modport is the buffer/link side.
interface elstc_buff_if #(
  parameter int COUNT_WIDTH   = 4,
  parameter int ERR_CNT_WIDTH = 8
);
  logic                     ctrl_en;
  logic [COUNT_WIDTH-1:0]   buff_count;
  logic                     full_sync;
  logic                     skp_boundary;
  logic                     elstc_buff_en;
  logic                     flush;
  logic                     rd_en;
  logic                     skp_add_rqst;
  logic                     skp_remv_rqst;
  logic                     buff_err;
  logic [ERR_CNT_WIDTH-1:0] err_count;

  modport master (
    input  ctrl_en, buff_count, full_sync, skp_boundary,
    output elstc_buff_en, flush, rd_en, skp_add_rqst, skp_remv_rqst, buff_err, err_count
  );

  modport slave (
    output ctrl_en, buff_count, full_sync, skp_boundary,
    input  elstc_buff_en, flush, rd_en, skp_add_rqst, skp_remv_rqst, buff_err, err_count
  );
endinterface

// File: rtl/elstc_buff_ctrl.sv
// RX elastic buffer sequencer: flush -> prime -> run, SKP-based re-centring, over/underflow
// detection with automatic re-flush.
//  state   | meaning
//  IDLE    | link inactive, buffer disabled
//  FLUSH   | pointers held in reset for FLUSH_CYCLES
//  PRIME   | writing, reads gated until fill reaches PRIME_LEVEL
//  RUN     | reads allowed, SKP add/remove requests at ordered-set boundaries
//  ERROR   | one-cycle error report, then re-flush
module elstc_buff_ctrl #(
  parameter int COUNT_WIDTH   = 4,
  parameter int DEPTH         = 8,
  parameter int LOW_WM        = 2,
  parameter int HIGH_WM       = 6,
  parameter int PRIME_LEVEL   = 4,
  parameter int FLUSH_CYCLES  = 4,
  parameter int PRIME_TMO     = 64,
  parameter int UFLOW_LIMIT   = 3,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic         local_clk,
  input  logic         local_rst,
  elstc_buff_if.master bus
);

  localparam int TMR_MAX = (PRIME_TMO > FLUSH_CYCLES) ? PRIME_TMO : FLUSH_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int UF_W    = $clog2(UFLOW_LIMIT + 1);

  localparam logic [TMR_W-1:0]       FLUSH_LAST = TMR_W'(FLUSH_CYCLES - 1);
  localparam logic [TMR_W-1:0]       PRIME_LAST = TMR_W'(PRIME_TMO - 1);
  localparam logic [UF_W-1:0]        UF_LAST    = UF_W'(UFLOW_LIMIT - 1);
  localparam logic [COUNT_WIDTH-1:0] LOW_LVL    = COUNT_WIDTH'(LOW_WM);
  localparam logic [COUNT_WIDTH-1:0] HIGH_LVL   = COUNT_WIDTH'(HIGH_WM);
  localparam logic [COUNT_WIDTH-1:0] PRIME_LVL  = COUNT_WIDTH'(PRIME_LEVEL);

  if (!(LOW_WM < PRIME_LEVEL && PRIME_LEVEL <= HIGH_WM && HIGH_WM <= DEPTH)) begin : g_cfg_check
    $error("elstc_buff_ctrl: watermarks must satisfy LOW_WM < PRIME_LEVEL <= HIGH_WM <= DEPTH");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_PRIME = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic [UF_W-1:0]          uflow_q, uflow_d;
  logic                     skp_add_q, skp_add_d;
  logic                     skp_remv_q, skp_remv_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

  always_ff @(posedge local_clk or negedge local_rst) begin
    if (!local_rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      uflow_q     <= '0;
      skp_add_q   <= 1'b0;
      skp_remv_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      uflow_q     <= uflow_d;
      skp_add_q   <= skp_add_d;
      skp_remv_q  <= skp_remv_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    uflow_d     = '0;
    skp_add_d   = 1'b0;
    skp_remv_d  = 1'b0;
    err_count_d = err_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.ctrl_en) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (timer_q == FLUSH_LAST) state_d = S_PRIME;
      end
      S_PRIME: begin
        if (bus.buff_count >= PRIME_LVL)  state_d = S_RUN;
        else if (timer_q == PRIME_LAST)   state_d = S_ERROR;
      end
      S_RUN: begin
        if (bus.full_sync) begin
          state_d = S_ERROR;
        end else if (bus.buff_count == '0 && uflow_q == UF_LAST) begin
          state_d = S_ERROR;
        end else begin
          if (bus.buff_count == '0) uflow_d = uflow_q + 1'b1;
          // A boundary landing on the cycle a request is visible is ignored.
          if (bus.skp_boundary && !(skp_add_q || skp_remv_q)) begin
            skp_add_d  = (bus.buff_count < LOW_LVL);
            skp_remv_d = (bus.buff_count > HIGH_LVL);
          end
        end
      end
      S_ERROR: begin
        state_d = S_FLUSH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!bus.ctrl_en) begin
      state_d    = S_IDLE;
      uflow_d    = '0;
      skp_add_d  = 1'b0;
      skp_remv_d = 1'b0;
    end

    if (state_d == state_q && (state_q == S_FLUSH || state_q == S_PRIME)) begin
      timer_d = timer_q + 1'b1;
    end

    // Counted on entry so err_count already reflects the error while buff_err is high.
    if (state_d == S_ERROR && err_count_q != '1) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  assign bus.elstc_buff_en = (state_q == S_PRIME) || (state_q == S_RUN);
  assign bus.flush         = (state_q == S_FLUSH);
  assign bus.rd_en         = (state_q == S_RUN);
  assign bus.buff_err      = (state_q == S_ERROR);
  assign bus.skp_add_rqst  = skp_add_q;
  assign bus.skp_remv_rqst = skp_remv_q;
  assign bus.err_count     = err_count_q;

endmodule

// File: tb/tb_elstc_buff_ctrl.sv
// Bench for elstc_buff_ctrl: directed stimulus; pulse outputs are checked by a scoreboard
// monitor, level outputs by direct checks in the stimulus flow.
module tb_elstc_buff_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  elstc_buff_if #(.COUNT_WIDTH(4), .ERR_CNT_WIDTH(8)) bus ();

  elstc_buff_ctrl dut (
    .local_clk (clk),
    .local_rst (rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic       add;
    logic       remv;
    logic       err;
    logic [7:0] cnt;
  } ev_t;

  ev_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void exp_ev(input logic a, input logic r, input logic e, input logic [7:0] c);
    ev_t ev;
    ev.add  = a;
    ev.remv = r;
    ev.err  = e;
    ev.cnt  = c;
    sb_q.push_back(ev);
  endfunction

  always @(negedge clk) begin : mon
    ev_t e;
    if (rst_n && (bus.skp_add_rqst || bus.skp_remv_rqst || bus.buff_err)) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: add=%0b remv=%0b err=%0b, expected no event (t=%0t)",
                 bus.skp_add_rqst, bus.skp_remv_rqst, bus.buff_err, $time);
      end else begin
        e = sb_q.pop_front();
        chk("evt_add",  int'(bus.skp_add_rqst),  int'(e.add));
        chk("evt_remv", int'(bus.skp_remv_rqst), int'(e.remv));
        chk("evt_err",  int'(bus.buff_err),      int'(e.err));
        if (e.err) chk("evt_err_count", int'(bus.err_count), int'(e.cnt));
      end
    end
  end

  // count, skp_boundary, expected add, expected remove
  int skp_tbl [13][4] = '{
    '{1,1,1,0}, '{4,0,0,0}, '{7,1,0,1}, '{4,0,0,0}, '{4,1,0,0}, '{4,0,0,0},
    '{2,1,0,0}, '{4,0,0,0}, '{6,1,0,0}, '{4,0,0,0}, '{1,1,1,0}, '{7,1,0,0},
    '{4,0,0,0}
  };

  initial begin
    bus.ctrl_en      = 1'b0;
    bus.buff_count   = '0;
    bus.full_sync    = 1'b0;
    bus.skp_boundary = 1'b0;
    rst_n            = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_en",        int'(bus.elstc_buff_en), 0);
    chk("rst_flush",     int'(bus.flush),         0);
    chk("rst_rd_en",     int'(bus.rd_en),         0);
    chk("rst_add",       int'(bus.skp_add_rqst),  0);
    chk("rst_remv",      int'(bus.skp_remv_rqst), 0);
    chk("rst_err",       int'(bus.buff_err),      0);
    chk("rst_err_count", int'(bus.err_count),     0);
    rst_n = 1'b1;

    // start-up: flush 4 cycles, prime, run once fill reaches 4
    @(negedge clk);
    bus.ctrl_en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i <= 4) begin
        chk("start_flush_hi", int'(bus.flush), 1);
        chk("start_en_lo",    int'(bus.elstc_buff_en), 0);
      end
      if (i == 5) begin
        chk("start_flush_lo", int'(bus.flush), 0);
        chk("prime_en",       int'(bus.elstc_buff_en), 1);
      end
      if (i == 8) chk("prime_rd_en_lo", int'(bus.rd_en), 0);
      if (i == 9) chk("run_rd_en_hi",   int'(bus.rd_en), 1);
      bus.buff_count = 4'(i / 2);
    end

    // SKP re-centring, watermark boundaries, back-to-back boundary suppression
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus.buff_count   = 4'(skp_tbl[i][0]);
      bus.skp_boundary = (skp_tbl[i][1] != 0);
      if (skp_tbl[i][2] != 0 || skp_tbl[i][3] != 0)
        exp_ev(skp_tbl[i][2] != 0, skp_tbl[i][3] != 0, 1'b0, 8'd0);
    end
    @(negedge clk);
    bus.skp_boundary = 1'b0;
    chk("skp_still_run", int'(bus.rd_en), 1);

    // overflow
    bus.full_sync = 1'b1;
    exp_ev(1'b0, 1'b0, 1'b1, 8'd1);
    @(negedge clk);
    bus.full_sync  = 1'b0;
    bus.buff_count = 4'd2;
    chk("ovf_err",       int'(bus.buff_err),      1);
    chk("ovf_err_count", int'(bus.err_count),     1);
    chk("ovf_en_lo",     int'(bus.elstc_buff_en), 0);
    chk("ovf_rd_en_lo",  int'(bus.rd_en),         0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ovf_reflush", int'(bus.flush), 1);
    end
    @(negedge clk);
    chk("ovf_prime_flush_lo", int'(bus.flush), 0);
    chk("ovf_prime_en",       int'(bus.elstc_buff_en), 1);
    chk("ovf_prime_rd_lo",    int'(bus.rd_en), 0);
    bus.buff_count = 4'd4;
    @(negedge clk);
    chk("ovf_back_run", int'(bus.rd_en), 1);

    // two empty cycles then data: no underflow
    bus.buff_count = 4'd0;
    @(negedge clk);
    @(negedge clk);
    bus.buff_count = 4'd1;
    @(negedge clk);
    bus.buff_count = 4'd4;
    @(negedge clk);
    chk("uflow2_no_err", int'(bus.buff_err), 0);
    chk("uflow2_run",    int'(bus.rd_en),    1);

    // three empty cycles: underflow
    bus.buff_count = 4'd0;
    exp_ev(1'b0, 1'b0, 1'b1, 8'd2);
    @(negedge clk);
    @(negedge clk);
    chk("uflow_not_yet", int'(bus.buff_err), 0);
    @(negedge clk);
    chk("uflow_err", int'(bus.buff_err), 1);
    bus.buff_count = 4'd4;
    repeat (6) @(negedge clk);
    chk("uflow_back_run", int'(bus.rd_en), 1);

    // prime timeout loop until err_count saturates
    bus.full_sync  = 1'b1;
    bus.buff_count = 4'd2;
    for (int n = 3; n <= 258; n++) exp_ev(1'b0, 1'b0, 1'b1, (n > 255) ? 8'd255 : 8'(n));
    @(negedge clk);
    bus.full_sync = 1'b0;
    chk("tmo_pre_count", int'(bus.err_count), 3);
    repeat (68) @(negedge clk);
    chk("tmo_last_prime_err", int'(bus.buff_err),      0);
    chk("tmo_last_prime_en",  int'(bus.elstc_buff_en), 1);
    chk("tmo_last_prime_rd",  int'(bus.rd_en),         0);
    @(negedge clk);
    chk("tmo_err",       int'(bus.buff_err),  1);
    chk("tmo_err_count", int'(bus.err_count), 4);
    for (int c = 0; c < 20000 && sb_q.size() != 0; c++) @(negedge clk);
    chk("sat_events_seen", sb_q.size(), 0);
    bus.buff_count = 4'd4;
    repeat (8) @(negedge clk);
    chk("sat_run",       int'(bus.rd_en),     1);
    chk("sat_err_count", int'(bus.err_count), 255);

    // ctrl_en drop mid-RUN beats a pending SKP boundary
    bus.ctrl_en      = 1'b0;
    bus.skp_boundary = 1'b1;
    bus.buff_count   = 4'd1;
    @(negedge clk);
    bus.skp_boundary = 1'b0;
    chk("off_en",        int'(bus.elstc_buff_en), 0);
    chk("off_flush",     int'(bus.flush),         0);
    chk("off_rd_en",     int'(bus.rd_en),         0);
    chk("off_err_count", int'(bus.err_count),     255);
    @(negedge clk);
    bus.ctrl_en = 1'b1;
    @(negedge clk);
    chk("restart_flush", int'(bus.flush), 1);

    // async reset mid-FLUSH
    #2 rst_n = 1'b0;
    #1;
    chk("arst_flush",     int'(bus.flush),         0);
    chk("arst_en",        int'(bus.elstc_buff_en), 0);
    chk("arst_err_count", int'(bus.err_count),     0);
    bus.ctrl_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", int'(bus.flush), 0);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
